// File: rtl/rv_mul_pkg.sv
// Shared encodings, FSM states and arithmetic helpers for the RV32M multiply sequencer.
package rv_mul_pkg;

  localparam logic [1:0] MUL_OP    = 2'b00;
  localparam logic [1:0] MULH_OP   = 2'b01;
  localparam logic [1:0] MULHSU_OP = 2'b10;
  localparam logic [1:0] MULHU_OP  = 2'b11;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FIX, DONE} state_e;

  // 0x80000000 negates to itself, so the most negative value is passed on as an unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

endpackage

// File: rtl/rv_mul_sign.sv
// Decodes operand signedness from funct3 and produces unsigned magnitudes plus the result sign.
module rv_mul_sign
  import rv_mul_pkg::*;
(
  input  logic [1:0]  funct3_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  output logic        s1_o,
  output logic        s2_o,
  output logic        neg_o,
  output logic [31:0] mag1_o,
  output logic [31:0] mag2_o
);

  always_comb begin
    s1_o   = (funct3_i == MULH_OP) || (funct3_i == MULHSU_OP);
    s2_o   = (funct3_i == MULH_OP);
    neg_o  = (s1_o && op1_i[31]) ^ (s2_o && op2_i[31]);
    mag1_o = abs32(op1_i, s1_o);
    mag2_o = abs32(op2_i, s2_o);
  end

endmodule

// File: rtl/rv_mul_ctrl.sv
// RV32M MUL/MULH/MULHSU/MULHU sequencer around an external unsigned 32x32 core,
// with a one-entry product cache so MULH*/MUL pairs on the same operands skip the core.
module rv_mul_ctrl
  import rv_mul_pkg::*;
#(
  parameter bit REUSE_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        ready_o,
  input  logic [1:0]  funct3_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic        flush_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o,
  output logic        busy_o,
  output logic        mul_ce_o,
  output logic [31:0] mul_op1_o,
  output logic [31:0] mul_op2_o,
  input  logic        mul_ce_i,
  input  logic [31:0] mul_lo_i,
  input  logic [31:0] mul_hi_i
);

  logic        sgn_s1, sgn_s2, sgn_neg;
  logic [31:0] sgn_mag1, sgn_mag2;

  rv_mul_sign u_sign (
    .funct3_i (funct3_i),
    .op1_i    (op1_i),
    .op2_i    (op2_i),
    .s1_o     (sgn_s1),
    .s2_o     (sgn_s2),
    .neg_o    (sgn_neg),
    .mag1_o   (sgn_mag1),
    .mag2_o   (sgn_mag2)
  );

  state_e      state_q, state_d;
  logic [1:0]  funct3_q, funct3_d;
  logic [31:0] op1_q, op1_d, op2_q, op2_d;
  logic        s1_q, s1_d, s2_q, s2_d, neg_q, neg_d;
  logic [31:0] mag1_q, mag1_d, mag2_q, mag2_d;
  logic [63:0] prod_q, prod_d;
  logic        pending_q, pending_d;
  logic        valid_q, valid_d;
  logic        mul_ce_q, mul_ce_d;
  logic [31:0] result_q, result_d;
  logic        cache_valid_q, cache_valid_d;
  logic [31:0] cache_op1_q, cache_op1_d, cache_op2_q, cache_op2_d;
  logic        cache_s1_q, cache_s1_d, cache_s2_q, cache_s2_d;
  logic [63:0] cache_prod_q, cache_prod_d;

  logic        accept, cache_hit, enter_done, fill_cache;
  logic [63:0] done_prod;
  logic [1:0]  done_funct3;

  assign ready_o   = (state_q == IDLE) && !pending_q;
  assign busy_o    = (state_q != IDLE) || pending_q;
  assign valid_o   = valid_q;
  assign result_o  = result_q;
  assign mul_ce_o  = mul_ce_q;
  assign mul_op1_o = mag1_q;
  assign mul_op2_o = mag2_q;

  always_comb begin
    state_d       = state_q;
    funct3_d      = funct3_q;
    op1_d         = op1_q;
    op2_d         = op2_q;
    s1_d          = s1_q;
    s2_d          = s2_q;
    neg_d         = neg_q;
    mag1_d        = mag1_q;
    mag2_d        = mag2_q;
    prod_d        = prod_q;
    valid_d       = valid_q;
    mul_ce_d      = 1'b0;
    result_d      = result_q;
    cache_valid_d = cache_valid_q;
    cache_op1_d   = cache_op1_q;
    cache_op2_d   = cache_op2_q;
    cache_s1_d    = cache_s1_q;
    cache_s2_d    = cache_s2_q;
    cache_prod_d  = cache_prod_q;
    enter_done    = 1'b0;
    fill_cache    = 1'b0;
    done_prod     = prod_q;
    done_funct3   = funct3_q;

    accept    = req_i && ready_o && !flush_i;
    cache_hit = REUSE_EN && cache_valid_q && (op1_i == cache_op1_q) && (op2_i == cache_op2_q) &&
                ((funct3_i == MUL_OP) || ((sgn_s1 == cache_s1_q) && (sgn_s2 == cache_s2_q)));

    // An issued operation always produces exactly one response, even if flushed meanwhile.
    pending_d = mul_ce_q ? 1'b1 : (mul_ce_i ? 1'b0 : pending_q);

    case (state_q)
      IDLE: begin
        if (accept) begin
          funct3_d = funct3_i;
          op1_d    = op1_i;
          op2_d    = op2_i;
          s1_d     = sgn_s1;
          s2_d     = sgn_s2;
          neg_d    = sgn_neg;
          mag1_d   = sgn_mag1;
          mag2_d   = sgn_mag2;
          if (cache_hit) begin
            state_d     = DONE;
            enter_done  = 1'b1;
            done_prod   = cache_prod_q;
            done_funct3 = funct3_i;
          end else begin
            state_d  = ISSUE;
            mul_ce_d = 1'b1;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mul_ce_i) begin
          prod_d    = {mul_hi_i, mul_lo_i};
          done_prod = {mul_hi_i, mul_lo_i};
          if (neg_q) begin
            state_d = FIX;
          end else begin
            state_d    = DONE;
            enter_done = 1'b1;
            fill_cache = 1'b1;
          end
        end
      end
      FIX: begin
        done_prod  = neg64(prod_q);
        state_d    = DONE;
        enter_done = 1'b1;
        fill_cache = 1'b1;
      end
      DONE: begin
        if (ready_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_done) begin
      prod_d   = done_prod;
      valid_d  = 1'b1;
      result_d = (done_funct3 == MUL_OP) ? done_prod[31:0] : done_prod[63:32];
    end

    // A hit keeps the existing entry so its signedness tag still describes the stored product.
    if (fill_cache) begin
      cache_valid_d = 1'b1;
      cache_op1_d   = op1_q;
      cache_op2_d   = op2_q;
      cache_s1_d    = s1_q;
      cache_s2_d    = s2_q;
      cache_prod_d  = done_prod;
    end

    if (flush_i) begin
      state_d       = IDLE;
      valid_d       = 1'b0;
      mul_ce_d      = 1'b0;
      cache_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      funct3_q      <= 2'b00;
      op1_q         <= 32'd0;
      op2_q         <= 32'd0;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      neg_q         <= 1'b0;
      mag1_q        <= 32'd0;
      mag2_q        <= 32'd0;
      prod_q        <= 64'd0;
      pending_q     <= 1'b0;
      valid_q       <= 1'b0;
      mul_ce_q      <= 1'b0;
      result_q      <= 32'd0;
      cache_valid_q <= 1'b0;
      cache_op1_q   <= 32'd0;
      cache_op2_q   <= 32'd0;
      cache_s1_q    <= 1'b0;
      cache_s2_q    <= 1'b0;
      cache_prod_q  <= 64'd0;
    end else begin
      state_q       <= state_d;
      funct3_q      <= funct3_d;
      op1_q         <= op1_d;
      op2_q         <= op2_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      neg_q         <= neg_d;
      mag1_q        <= mag1_d;
      mag2_q        <= mag2_d;
      prod_q        <= prod_d;
      pending_q     <= pending_d;
      valid_q       <= valid_d;
      mul_ce_q      <= mul_ce_d;
      result_q      <= result_d;
      cache_valid_q <= cache_valid_d;
      cache_op1_q   <= cache_op1_d;
      cache_op2_q   <= cache_op2_d;
      cache_s1_q    <= cache_s1_d;
      cache_s2_q    <= cache_s2_d;
      cache_prod_q  <= cache_prod_d;
    end
  end

endmodule

// File: tb/tb_rv_mul_ctrl.sv
// Directed bench for rv_mul_ctrl with a variable-latency unsigned multiplier core model.
module tb_rv_mul_ctrl;
  import rv_mul_pkg::*;

  logic        clk_i, rst_ni, req_i, ready_o, flush_i, valid_o, ready_i, busy_o;
  logic [1:0]  funct3_i;
  logic [31:0] op1_i, op2_i, result_o, mul_op1_o, mul_op2_o, mul_lo_i, mul_hi_i;
  logic        mul_ce_o, mul_ce_i;

  int          n_checks, n_pass, core_lat;
  logic [3:0]  core_cnt;
  logic [63:0] core_prod;

  rv_mul_ctrl #(.REUSE_EN(1'b1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .ready_o(ready_o),
    .funct3_i(funct3_i), .op1_i(op1_i), .op2_i(op2_i), .flush_i(flush_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .busy_o(busy_o),
    .mul_ce_o(mul_ce_o), .mul_op1_o(mul_op1_o), .mul_op2_o(mul_op2_o),
    .mul_ce_i(mul_ce_i), .mul_lo_i(mul_lo_i), .mul_hi_i(mul_hi_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Core responds core_lat cycles after the issue strobe and is reset with the controller.
  always @(posedge clk_i) begin
    if (!rst_ni) begin
      core_cnt <= 4'd0;
      mul_ce_i <= 1'b0;
    end else if (mul_ce_o && core_lat == 1) begin
      mul_ce_i              <= 1'b1;
      {mul_hi_i, mul_lo_i}  <= 64'(mul_op1_o) * 64'(mul_op2_o);
      core_cnt              <= 4'd0;
    end else if (mul_ce_o) begin
      mul_ce_i  <= 1'b0;
      core_cnt  <= 4'(core_lat - 1);
      core_prod <= 64'(mul_op1_o) * 64'(mul_op2_o);
    end else if (core_cnt == 4'd1) begin
      mul_ce_i             <= 1'b1;
      {mul_hi_i, mul_lo_i} <= core_prod;
      core_cnt             <= 4'd0;
    end else begin
      mul_ce_i <= 1'b0;
      if (core_cnt > 4'd1) core_cnt <= core_cnt - 4'd1;
    end
  end

  task automatic run_op(input logic [1:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output bit saw_ce, output logic [31:0] ce_a,
                        output logic [31:0] ce_b, output logic [31:0] res);
    @(negedge clk_i);
    funct3_i = f3; op1_i = a; op2_i = b; req_i = 1'b1; ready_i = 1'b0;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    lat = 1; saw_ce = 1'b0; ce_a = 32'd0; ce_b = 32'd0;
    while (!valid_o && lat < 40) begin
      if (mul_ce_o) begin saw_ce = 1'b1; ce_a = mul_op1_o; ce_b = mul_op2_o; end
      @(posedge clk_i); #1;
      lat++;
    end
    res = result_o;
  endtask

  task automatic finish_op();
    @(negedge clk_i); ready_i = 1'b1;
    @(posedge clk_i); #1; ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; req_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
    funct3_i = 2'b00; op1_i = 32'd0; op2_i = 32'd0; core_lat = 1;
    repeat (2) @(posedge clk_i);
    #1;
    n_checks++; if (ready_o !== 1'b1) $display("[TB] FAIL reset_ready: got %b want 1", ready_o); else n_pass++;
    n_checks++; if (valid_o !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", valid_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy_o); else n_pass++;
    n_checks++; if (mul_ce_o !== 1'b0) $display("[TB] FAIL reset_mul_ce: got %b want 0", mul_ce_o); else n_pass++;
    n_checks++; if (result_o !== 32'd0) $display("[TB] FAIL reset_result: got %h want 0", result_o); else n_pass++;
    n_checks++; if (mul_op1_o !== 32'd0) $display("[TB] FAIL reset_op1: got %h want 0", mul_op1_o); else n_pass++;
    n_checks++; if (mul_op2_o !== 32'd0) $display("[TB] FAIL reset_op2: got %h want 0", mul_op2_o); else n_pass++;
    @(negedge clk_i); rst_ni = 1'b1;
  endtask

  task automatic test_mulhu_basic();
    int lat; bit ce; logic [31:0] a, b, r;
    core_lat = 1;
    run_op(MULHU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, ce, a, b, r);
    n_checks++; if (lat !== 3) $display("[TB] FAIL mulhu_latency: got %0d want 3", lat); else n_pass++;
    n_checks++; if (ce !== 1'b1) $display("[TB] FAIL mulhu_issue: got %b want 1", ce); else n_pass++;
    n_checks++; if (a !== 32'hFFFF_FFFF || b !== 32'hFFFF_FFFF) $display("[TB] FAIL mulhu_mags: got %h/%h want ffffffff/ffffffff", a, b); else n_pass++;
    n_checks++; if (r !== 32'hFFFF_FFFE) $display("[TB] FAIL mulhu_result: got %h want fffffffe", r); else n_pass++;
    n_checks++; if (ready_o !== 1'b0) $display("[TB] FAIL mulhu_ready_in_done: got %b want 0", ready_o); else n_pass++;
    finish_op();
  endtask

  task automatic test_sign_fix_and_reuse();
    int lat; bit ce; logic [31:0] a, b, r;
    run_op(MULH_OP, 32'hFFFF_FFFF, 32'h0000_0002, lat, ce, a, b, r);
    n_checks++; if (lat !== 4) $display("[TB] FAIL mulh_latency: got %0d want 4", lat); else n_pass++;
    n_checks++; if (a !== 32'd1 || b !== 32'd2) $display("[TB] FAIL mulh_mags: got %h/%h want 1/2", a, b); else n_pass++;
    n_checks++; if (r !== 32'hFFFF_FFFF) $display("[TB] FAIL mulh_result: got %h want ffffffff", r); else n_pass++;
    finish_op();
    run_op(MUL_OP, 32'hFFFF_FFFF, 32'h0000_0002, lat, ce, a, b, r);
    n_checks++; if (lat !== 1) $display("[TB] FAIL mul_hit_latency: got %0d want 1", lat); else n_pass++;
    n_checks++; if (ce !== 1'b0) $display("[TB] FAIL mul_hit_no_issue: got %b want 0", ce); else n_pass++;
    n_checks++; if (r !== 32'hFFFF_FFFE) $display("[TB] FAIL mul_hit_result: got %h want fffffffe", r); else n_pass++;
    finish_op();
  endtask

  task automatic test_mulhsu_cache_miss();
    int lat; bit ce; logic [31:0] a, b, r;
    run_op(MULHSU_OP, 32'h8000_0000, 32'hFFFF_FFFF, lat, ce, a, b, r);
    n_checks++; if (a !== 32'h8000_0000 || b !== 32'hFFFF_FFFF) $display("[TB] FAIL mulhsu_mags: got %h/%h want 80000000/ffffffff", a, b); else n_pass++;
    n_checks++; if (lat !== 4) $display("[TB] FAIL mulhsu_latency: got %0d want 4", lat); else n_pass++;
    n_checks++; if (r !== 32'h8000_0000) $display("[TB] FAIL mulhsu_result: got %h want 80000000", r); else n_pass++;
    finish_op();
    run_op(MULHU_OP, 32'h8000_0000, 32'hFFFF_FFFF, lat, ce, a, b, r);
    n_checks++; if (ce !== 1'b1) $display("[TB] FAIL mulhu_after_mulhsu_issue: got %b want 1", ce); else n_pass++;
    n_checks++; if (lat !== 3) $display("[TB] FAIL mulhu_after_mulhsu_latency: got %0d want 3", lat); else n_pass++;
    n_checks++; if (r !== 32'h7FFF_FFFF) $display("[TB] FAIL mulhu_after_mulhsu_result: got %h want 7fffffff", r); else n_pass++;
    finish_op();
  endtask

  task automatic test_backpressure();
    int lat; bit ce; logic [31:0] a, b, r;
    run_op(MUL_OP, 32'd7, 32'd6, lat, ce, a, b, r);
    n_checks++; if (r !== 32'd42) $display("[TB] FAIL hold_first_result: got %h want 2a", r); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      n_checks++; if (valid_o !== 1'b1) $display("[TB] FAIL hold_valid[%0d]: got %b want 1", i, valid_o); else n_pass++;
      n_checks++; if (result_o !== 32'd42) $display("[TB] FAIL hold_result[%0d]: got %h want 2a", i, result_o); else n_pass++;
      n_checks++; if (ready_o !== 1'b0) $display("[TB] FAIL hold_ready[%0d]: got %b want 0", i, ready_o); else n_pass++;
    end
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    n_checks++; if (valid_o !== 1'b0) $display("[TB] FAIL release_valid: got %b want 0", valid_o); else n_pass++;
    n_checks++; if (ready_o !== 1'b1) $display("[TB] FAIL release_ready: got %b want 1", ready_o); else n_pass++;
  endtask

  task automatic test_flush_drain();
    int lat, n; bit ce, saw_valid, saw_resp; logic [31:0] a, b, r;
    core_lat = 4;
    run_op(MULHU_OP, 32'd5, 32'd9, lat, ce, a, b, r);
    n_checks++; if (lat !== 6) $display("[TB] FAIL slow_core_latency: got %0d want 6", lat); else n_pass++;
    n_checks++; if (r !== 32'd0) $display("[TB] FAIL slow_core_result: got %h want 0", r); else n_pass++;
    finish_op();
    @(negedge clk_i);
    funct3_i = MULH_OP; op1_i = 32'd5; op2_i = 32'd9; req_i = 1'b1;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    n_checks++; if (mul_ce_o !== 1'b1) $display("[TB] FAIL flush_op_issue: got %b want 1", mul_ce_o); else n_pass++;
    @(posedge clk_i); #1;
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    // Request and flush are held through the stale response and one cycle past it.
    funct3_i = MUL_OP; op1_i = 32'd1; op2_i = 32'd1; req_i = 1'b1;
    n_checks++; if (busy_o !== 1'b1) $display("[TB] FAIL flush_busy_pending: got %b want 1", busy_o); else n_pass++;
    n = 0; saw_valid = 1'b0; saw_resp = 1'b0;
    while (!ready_o && n < 20) begin
      if (valid_o) saw_valid = 1'b1;
      if (mul_ce_i) saw_resp = 1'b1;
      @(posedge clk_i); #1;
      n++;
    end
    n_checks++; if (n !== 3) $display("[TB] FAIL flush_drain_cycles: got %0d want 3", n); else n_pass++;
    n_checks++; if (saw_resp !== 1'b1) $display("[TB] FAIL flush_stale_resp: got %b want 1", saw_resp); else n_pass++;
    n_checks++; if (saw_valid !== 1'b0) $display("[TB] FAIL flush_no_valid: got %b want 0", saw_valid); else n_pass++;
    @(posedge clk_i); #1;
    n_checks++; if (mul_ce_o !== 1'b0) $display("[TB] FAIL flush_drops_req: got %b want 0", mul_ce_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("[TB] FAIL flush_idle_busy: got %b want 0", busy_o); else n_pass++;
    req_i = 1'b0; flush_i = 1'b0;
    run_op(MULHU_OP, 32'd5, 32'd9, lat, ce, a, b, r);
    n_checks++; if (ce !== 1'b1) $display("[TB] FAIL flush_invalidated_cache: got %b want 1", ce); else n_pass++;
    n_checks++; if (lat !== 6) $display("[TB] FAIL reissue_latency: got %0d want 6", lat); else n_pass++;
    finish_op();
    run_op(MUL_OP, 32'd5, 32'd9, lat, ce, a, b, r);
    n_checks++; if (lat !== 1 || ce !== 1'b0) $display("[TB] FAIL refill_hit: got lat %0d ce %b want 1/0", lat, ce); else n_pass++;
    n_checks++; if (r !== 32'd45) $display("[TB] FAIL refill_result: got %h want 2d", r); else n_pass++;
    finish_op();
  endtask

  task automatic test_reset_in_fix();
    int lat; bit ce; logic [31:0] a, b, r;
    core_lat = 1;
    @(negedge clk_i);
    funct3_i = MULH_OP; op1_i = 32'hFFFF_FFFD; op2_i = 32'd4; req_i = 1'b1;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    repeat (2) begin @(posedge clk_i); #1; end
    n_checks++; if (busy_o !== 1'b1 || valid_o !== 1'b0) $display("[TB] FAIL fix_state: got busy %b valid %b want 1/0", busy_o, valid_o); else n_pass++;
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    n_checks++; if (valid_o !== 1'b0) $display("[TB] FAIL fix_reset_valid: got %b want 0", valid_o); else n_pass++;
    n_checks++; if (ready_o !== 1'b1) $display("[TB] FAIL fix_reset_ready: got %b want 1", ready_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("[TB] FAIL fix_reset_busy: got %b want 0", busy_o); else n_pass++;
    n_checks++; if (result_o !== 32'd0) $display("[TB] FAIL fix_reset_result: got %h want 0", result_o); else n_pass++;
    run_op(MUL_OP, 32'd3, 32'd5, lat, ce, a, b, r);
    n_checks++; if (lat !== 3) $display("[TB] FAIL post_reset_latency: got %0d want 3", lat); else n_pass++;
    n_checks++; if (r !== 32'd15) $display("[TB] FAIL post_reset_result: got %h want f", r); else n_pass++;
    finish_op();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_mulhu_basic();
    test_sign_fix_and_reuse();
    test_mulhsu_cache_miss();
    test_backpressure();
    test_flush_drain();
    test_reset_in_fix();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
